// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds the FSM state enum, the latched request payload and the byte-enable mask helper.
package mem_pkg;

  localparam int unsigned DMEM_DEPTH_WORDS = 256;
  localparam int unsigned DMEM_LATENCY     = 2;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned BE_W             = 4;
  localparam int unsigned CNT_W            = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dmem_req_t;

  // Expand per-lane byte enables into a 32-bit bit mask.
  function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < int'(BE_W); i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-enabled write, combinational read.
// Contents are never reset.
module dmem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [DATA_W-1:0]              i_wdata,
  input  logic [BE_W-1:0]                i_be,
  output logic [DATA_W-1:0]              o_rdata_c
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] w_mask;

  assign w_mask = be_to_mask(i_be);

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= (r_mem[i_addr] & ~w_mask) | (i_wdata & w_mask);
    end
  end

  assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one request, waits LATENCY
// cycles, performs the access on entry to RESP and holds the response until taken.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DMEM_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned      AW       = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  dmem_req_t         r_req;
  dmem_req_t         w_acc;
  logic              w_accept;
  logic              w_enter_resp;
  logic              w_err;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_rdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  // In IDLE the live inputs feed the access (needed when LATENCY is 0); otherwise the latched copy.
  always_comb begin
    w_acc = r_req;
    if (r_state == IDLE) begin
      w_acc.write = req_write;
      w_acc.addr  = req_addr;
      w_acc.wdata = req_wdata;
      w_acc.be    = req_be;
    end
  end

  assign w_accept     = (r_state == IDLE) && req_valid;
  assign w_err        = (w_acc.addr[1:0] != 2'b00) || (w_acc.addr[31:2] >= 30'(DEPTH_WORDS));
  assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);
  assign w_mem_we     = w_enter_resp && w_acc.write && !w_err;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req <= w_acc;
    end
  end

  // Response is captured on the same edge the memory access happens.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_enter_resp) begin
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (w_err || w_acc.write) ? '0 : w_rdata;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk      (clk),
    .i_we     (w_mem_we),
    .i_addr   (w_acc.addr[AW+1:2]),
    .i_wdata  (w_acc.wdata),
    .i_be     (w_acc.be),
    .o_rdata_c(w_rdata)
  );

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default-latency instance plus a LATENCY=0 instance.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic        z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_be;

  int n_vec  = 0;
  int n_miss = 0;

  dmem_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction on the default instance; lat counts cycles from accept to first rsp_valid.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    // Garbage on the request bus after acceptance must be ignored.
    req_valid = 1'b0; req_write = ~w; req_addr = a ^ 32'h4; req_wdata = ~d; req_be = ~be;
    n = 1;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    lat = rsp_valid ? n : 0;
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic txn0(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    z_req_valid = 1'b1; z_req_write = w; z_req_addr = a; z_req_wdata = d; z_req_be = be; z_rsp_ready = 1'b0;
    n = 0;
    while (!z_req_ready && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    z_req_valid = 1'b0; z_req_addr = a ^ 32'h4; z_req_wdata = ~d;
    n = 1;
    while (!z_rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    lat = z_rsp_valid ? n : 0;
    rd = z_rsp_rdata; er = z_rsp_err;
    z_rsp_ready = 1'b1;
    @(posedge clk); #1;
    z_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_dut: ready=%b valid=%b rdata=%h err=%b, expected 1 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    n_vec++;
    if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0 || z_rsp_rdata !== 32'h0 || z_rsp_err !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_dut0: ready=%b valid=%b rdata=%h err=%b, expected 1 0 00000000 0",
               z_req_ready, z_rsp_valid, z_rsp_rdata, z_rsp_err);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== 3) begin
      n_miss++; $display("FAIL store_10: rdata=%h err=%b lat=%0d, expected 00000000 0 3", rd, er, lat);
    end
    txn(1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin
      n_miss++; $display("FAIL load_10: rdata=%h err=%b lat=%0d, expected deadbeef 0 3", rd, er, lat);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
    txn(1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'hDEADBEAA || er !== 1'b0) begin
      n_miss++; $display("FAIL be_0001: rdata=%h err=%b, expected deadbeaa 0", rd, er);
    end
    txn(1'b1, 32'h10, 32'h12345678, 4'b0000, rd, er, lat);
    n_vec++;
    if (er !== 1'b0 || lat !== 3) begin
      n_miss++; $display("FAIL be_0000_store: err=%b lat=%0d, expected 0 3", er, lat);
    end
    txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    n_vec++;
    if (rd !== 32'hDEADBEAA) begin
      n_miss++; $display("FAIL be_0000_load: rdata=%h, expected deadbeaa", rd);
    end
    txn(1'b1, 32'h4, 32'h11223344, 4'b1111, rd, er, lat);
    txn(1'b1, 32'h4, 32'hAABBCCDD, 4'b1010, rd, er, lat);
    txn(1'b0, 32'h4, 32'h0, 4'b0001, rd, er, lat);
    n_vec++;
    if (rd !== 32'hAA22CC44 || er !== 1'b0) begin
      n_miss++; $display("FAIL be_1010: rdata=%h err=%b, expected aa22cc44 0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, rd, er, lat);
    txn(1'b0, 32'h13, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'h0 || er !== 1'b1 || lat !== 3) begin
      n_miss++; $display("FAIL misaligned_load: rdata=%h err=%b lat=%0d, expected 00000000 1 3", rd, er, lat);
    end
    txn(1'b0, 32'h400, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_miss++; $display("FAIL range_load_400: rdata=%h err=%b, expected 00000000 1", rd, er);
    end
    txn(1'b0, 32'hFFFFFFFC, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      n_miss++; $display("FAIL range_load_top: rdata=%h err=%b, expected 00000000 1", rd, er);
    end
    txn(1'b1, 32'h400, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (er !== 1'b1) begin
      n_miss++; $display("FAIL range_store_err: err=%b, expected 1", er);
    end
    txn(1'b1, 32'h11, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (er !== 1'b1) begin
      n_miss++; $display("FAIL misaligned_store_err: err=%b, expected 1", er);
    end
    txn(1'b0, 32'h0, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      n_miss++; $display("FAIL word0_intact: rdata=%h err=%b, expected cafef00d 0", rd, er);
    end
    txn(1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'hDEADBEAA || er !== 1'b0) begin
      n_miss++; $display("FAIL word10_intact: rdata=%h err=%b, expected deadbeaa 0", rd, er);
    end
    txn(1'b1, 32'h3FC, 32'h87654321, 4'b1111, rd, er, lat);
    txn(1'b0, 32'h3FC, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'h87654321 || er !== 1'b0) begin
      n_miss++; $display("FAIL last_word: rdata=%h err=%b, expected 87654321 0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int n;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF; rsp_ready = 1'b0;
    @(posedge clk); #1;
    // A competing store held on the bus during WAIT/RESP must not be taken.
    req_write = 1'b1; req_wdata = 32'h0;
    n_vec++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_miss++; $display("FAIL bp_wait: ready=%b valid=%b, expected 0 0", req_ready, rsp_valid);
    end
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'hDEADBEAA || rsp_err !== 1'b0) begin
        n_miss++;
        $display("FAIL bp_hold_%0d: valid=%b ready=%b rdata=%h err=%b, expected 1 0 deadbeaa 0",
                 i, rsp_valid, req_ready, rsp_rdata, rsp_err);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_miss++; $display("FAIL bp_release: valid=%b ready=%b, expected 0 1", rsp_valid, req_ready);
    end
    txn(1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'hDEADBEAA) begin
      n_miss++; $display("FAIL bp_no_write: rdata=%h, expected deadbeaa", rd);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h20, 32'h01020304, 4'b1111, rd, er, lat);
    txn(1'b0, 32'h20, 32'h0, 4'b1111, rd, er, lat);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_miss++;
      $display("FAIL abort_reset_vals: ready=%b valid=%b rdata=%h err=%b, expected 1 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_miss++; $display("FAIL abort_no_rsp_%0d: valid=%b ready=%b, expected 0 1", i, rsp_valid, req_ready);
      end
    end
    txn(1'b0, 32'h20, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'h01020304 || er !== 1'b0) begin
      n_miss++; $display("FAIL abort_mem_kept: rdata=%h err=%b, expected 01020304 0", rd, er);
    end
  endtask

  task automatic test_latency0();
    logic [31:0] rd; logic er; int lat;
    txn0(1'b1, 32'h8, 32'h55AA55AA, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== 1) begin
      n_miss++; $display("FAIL lat0_store: rdata=%h err=%b lat=%0d, expected 00000000 0 1", rd, er, lat);
    end
    txn0(1'b0, 32'h8, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'h55AA55AA || er !== 1'b0 || lat !== 1) begin
      n_miss++; $display("FAIL lat0_load: rdata=%h err=%b lat=%0d, expected 55aa55aa 0 1", rd, er, lat);
    end
    txn0(1'b0, 32'h9, 32'h0, 4'b1111, rd, er, lat);
    n_vec++;
    if (rd !== 32'h0 || er !== 1'b1 || lat !== 1) begin
      n_miss++; $display("FAIL lat0_misaligned: rdata=%h err=%b lat=%0d, expected 00000000 1 1", rd, er, lat);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0; z_rsp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_abort();
    test_latency0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
